// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU decode/issue stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRL = 3'b110,
        ALU_SRA = 3'b111
    } alu_op_t;

    localparam logic [6:0] OP_REG = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;

    typedef struct packed {
        logic [XLEN-1:0] ain;
        logic [XLEN-1:0] bin;
        alu_op_t         alu_op;
        logic [4:0]      rd;
        logic            rd_we;
        logic            illegal;
    } issue_t;

    // Value held by the output registers out of reset.
    localparam issue_t ISSUE_IDLE = '{
        ain:     '0,
        bin:     '0,
        alu_op:  ALU_ADD,
        rd:      5'd0,
        rd_we:   1'b0,
        illegal: 1'b0
    };

endpackage

// File: rtl/skid_buffer.sv
// Two-entry valid/ready register slice carrying issue_t, with synchronous flush.
// Latency: 1 cycle from input transfer to out_valid.
// Backpressure: in_ready = !skid_full (straight from a flop); one extra beat is absorbed after out_ready drops.
//
// Ports: clk, rst (async, active-high), flush,
//        in_valid/in_ready/in_data (upstream), out_valid/out_ready/out_data (downstream).
module skid_buffer
    import alu_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   flush,
    input  logic   in_valid,
    output logic   in_ready,
    input  issue_t in_data,
    output logic   out_valid,
    input  logic   out_ready,
    output issue_t out_data
);

    logic   prim_vld;
    issue_t prim_dat;
    logic   skid_vld;
    issue_t skid_dat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prim_vld <= 1'b0;
            prim_dat <= ISSUE_IDLE;
            skid_vld <= 1'b0;
            skid_dat <= ISSUE_IDLE;
        end else if (flush) begin
            // Any output transfer on this edge has already happened from the
            // downstream side; only the buffered state is discarded, and the
            // input beat is dropped.
            prim_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (!prim_vld || out_ready) begin
            // Primary is empty or draining this edge: refill from skid first
            // (keeps order), otherwise from the input. in_ready is 0 whenever
            // skid is full, so both cannot compete.
            if (skid_vld) begin
                prim_dat <= skid_dat;
                prim_vld <= 1'b1;
                skid_vld <= 1'b0;
            end else if (in_valid) begin
                prim_dat <= in_data;
                prim_vld <= 1'b1;
            end else begin
                prim_vld <= 1'b0;
            end
        end else if (in_valid && !skid_vld) begin
            // Primary stalled: the beat accepted on a still-high in_ready
            // lands in the skid register.
            skid_dat <= in_data;
            skid_vld <= 1'b1;
        end
    end

    assign in_ready  = !skid_vld;
    assign out_valid = prim_vld;
    assign out_data  = prim_dat;

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage: RV32I R/I-type ALU instructions -> ALU op and operands.
// Latency: 1 cycle (combinational decode into a registered two-entry slice).
// Backpressure: in_ready registered, drops one cycle after out_ready stalls a valid output.
//
// Ports: clk, rst (async, active-high), flush (sync),
//        in_valid/in_ready, instr, rs1_data, rs2_data (upstream),
//        out_valid/out_ready, ain, bin, alu_op, rd, rd_we, illegal (to execute).
module alu_issue_stage
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] ain,
    output logic [31:0] bin,
    output logic [2:0]  alu_op,
    output logic [4:0]  rd,
    output logic        rd_we,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd_idx;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign rd_idx = instr[11:7];

    // The rs1 index is consumed by the register file upstream; its data
    // arrives on rs1_data, so the field itself is not needed here.
    logic unused_rs1_idx;
    assign unused_rs1_idx = ^instr[19:15];

    logic        legal;
    alu_op_t     dec_op;
    logic [31:0] dec_b;
    issue_t      dec;

    always_comb begin
        legal  = 1'b0;
        dec_op = ALU_ADD;
        dec_b  = rs2_data;
        case (opcode)
            OP_REG: begin
                dec_b = rs2_data;
                legal = 1'b1;
                case ({funct7, funct3})
                    {7'b0000000, 3'b000}: dec_op = ALU_ADD;
                    {7'b0000000, 3'b111}: dec_op = ALU_AND;
                    {7'b0000000, 3'b110}: dec_op = ALU_OR;
                    {7'b0000000, 3'b100}: dec_op = ALU_XOR;
                    {7'b0000000, 3'b001}: dec_op = ALU_SLL;
                    {7'b0000000, 3'b101}: dec_op = ALU_SRL;
                    {7'b0100000, 3'b000}: dec_op = ALU_SUB;
                    {7'b0100000, 3'b101}: dec_op = ALU_SRA;
                    default:              legal  = 1'b0;
                endcase
            end
            OP_IMM: begin
                dec_b = {{20{instr[31]}}, instr[31:20]};
                legal = 1'b1;
                case (funct3)
                    3'b000: dec_op = ALU_ADD;
                    3'b111: dec_op = ALU_AND;
                    3'b110: dec_op = ALU_OR;
                    3'b100: dec_op = ALU_XOR;
                    3'b001: begin
                        dec_op = ALU_SLL;
                        dec_b  = {27'b0, instr[24:20]};
                        legal  = (funct7 == 7'b0000000);
                    end
                    3'b101: begin
                        dec_b = {27'b0, instr[24:20]};
                        if (funct7 == 7'b0000000) begin
                            dec_op = ALU_SRL;
                        end else if (funct7 == 7'b0100000) begin
                            dec_op = ALU_SRA;
                        end else begin
                            legal = 1'b0;
                        end
                    end
                    // 010/011 are SLTI/SLTIU: the ALU has no compare op.
                    default: legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase
    end

    // Illegal instructions still flow through as a harmless ADD 0,0 with no
    // write-back so execute sees an ordered slot it can trap on.
    always_comb begin
        dec         = ISSUE_IDLE;
        dec.rd      = rd_idx;
        dec.illegal = !legal;
        if (legal) begin
            dec.ain    = rs1_data;
            dec.bin    = dec_b;
            dec.alu_op = dec_op;
            dec.rd_we  = (rd_idx != 5'd0);
        end
    end

    issue_t out_dat;

    skid_buffer u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (dec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_dat)
    );

    assign ain     = out_dat.ain;
    assign bin     = out_dat.bin;
    assign alu_op  = out_dat.alu_op;
    assign rd      = out_dat.rd;
    assign rd_we   = out_dat.rd_we;
    assign illegal = out_dat.illegal;

endmodule
